// File: rtl/pipe_control_unit_if.sv
// Pipeline control bundle: D-stage instruction in, stall/flush, multdiv handshake and X/M/W controls out.
// Latency: wires only; timing belongs to pipe_control_unit.
// Backpressure: none here; stall_fd is the hold request back to the front end.
//
// Ports: master = datapath side (drives the instruction and status inputs);
//        slave  = pipe_control_unit (drives stall/flush, multdiv handshake and stage controls).
interface pipe_control_unit_if #(
    parameter int CNT_W = 8
);
    logic [31:0]      insn_d;
    logic             insn_valid_d;
    logic             branch_taken_x;
    logic             md_ready;

    logic             stall_fd;
    logic             flush_fd;
    logic             md_start;
    logic             md_is_div;
    logic             md_timeout;
    logic [CNT_W-1:0] md_count;

    logic             x_valid;
    logic             x_alu_in_b;
    logic             x_br;
    logic             x_brlt;
    logic             x_jp;
    logic             x_jr;
    logic             x_md;
    logic [4:0]       x_alu_op;

    logic             m_valid;
    logic             m_dmwe;

    logic             w_valid;
    logic             w_we;
    logic             w_rwd;
    logic             w_jal;
    logic [4:0]       w_rd;

    modport master (
        output insn_d, insn_valid_d, branch_taken_x, md_ready,
        input  stall_fd, flush_fd, md_start, md_is_div, md_timeout, md_count,
        input  x_valid, x_alu_in_b, x_br, x_brlt, x_jp, x_jr, x_md, x_alu_op,
        input  m_valid, m_dmwe,
        input  w_valid, w_we, w_rwd, w_jal, w_rd
    );

    modport slave (
        input  insn_d, insn_valid_d, branch_taken_x, md_ready,
        output stall_fd, flush_fd, md_start, md_is_div, md_timeout, md_count,
        output x_valid, x_alu_in_b, x_br, x_brlt, x_jp, x_jr, x_md, x_alu_op,
        output m_valid, m_dmwe,
        output w_valid, w_we, w_rwd, w_jal, w_rd
    );
endinterface

// File: rtl/pipe_control_unit.sv
// 5-stage pipeline control: D decode, X/M/W control registers, load-use stall, branch flush, mul/div hold.
// Latency: controls of a D instruction accepted at cycle N appear in X at N+1, M at N+2, W at N+3.
// Backpressure: stall_fd holds the front end (load-use one cycle, mul/div until md_ready or timeout).
//
// Ports: clock, reset (sync, active-high); bus = pipe_control_unit_if.slave carrying insn_d/insn_valid_d,
//        branch_taken_x, md_ready in and stall_fd, flush_fd, md_* handshake, x_/m_/w_ controls out.
module pipe_control_unit #(
    parameter int MD_MAX_CYCLES = 33,
    parameter int CNT_W         = 8
) (
    input  logic               clock,
    input  logic               reset,
    pipe_control_unit_if.slave bus
);
    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_J     = 5'b00001;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_JAL   = 5'b00011;
    localparam logic [4:0] OP_JR    = 5'b00100;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_SETX  = 5'b10101;
    localparam logic [4:0] OP_BEX   = 5'b10110;
    localparam logic [4:0] ALU_MUL  = 5'b00110;
    localparam logic [4:0] ALU_DIV  = 5'b00111;
    localparam logic [4:0] ALU_NOP  = 5'b01000;

    // X stage carries everything later stages and the hazard logic need.
    typedef struct packed {
        logic       valid;
        logic [4:0] alu_op;
        logic       alu_in_b;
        logic       br;
        logic       brlt;
        logic       jp;
        logic       jr;
        logic       md;
        logic       div;
        logic       lw;
        logic       dmwe;
        logic       rwd;
        logic       jal;
        logic       we;
        logic [4:0] rd;
    } x_ctl_t;

    typedef struct packed {
        logic       valid;
        logic       dmwe;
        logic       rwd;
        logic       jal;
        logic       we;
        logic [4:0] rd;
    } m_ctl_t;

    typedef struct packed {
        logic       valid;
        logic       we;
        logic       rwd;
        logic       jal;
        logic [4:0] rd;
    } w_ctl_t;

    typedef enum logic {IDLE, BUSY} md_state_t;

    logic [31:0] insn;
    logic [4:0]  op, alu, f_rd, f_rs, f_rt;
    logic        unused_insn_bits;

    assign insn             = bus.insn_d;
    assign op               = insn[31:27];
    assign alu              = insn[6:2];
    assign f_rd             = insn[26:22];
    assign f_rs             = insn[21:17];
    assign f_rt             = insn[16:12];
    assign unused_insn_bits = ^{insn[11:7], insn[1:0]};

    x_ctl_t    d_ctl, x_q;
    m_ctl_t    m_d, m_q;
    w_ctl_t    w_q;
    md_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic use_rd, use_rs, use_rt, use_r30;
    logic load_use, md_active, at_max;
    logic md_hold, md_start, md_timeout, stall_fd, flush_fd;

    // ---------------- D-stage decode ----------------
    always_comb begin
        d_ctl   = '0;
        use_rd  = 1'b0;
        use_rs  = 1'b0;
        use_rt  = 1'b0;
        use_r30 = 1'b0;
        d_ctl.rd = f_rd;
        case (op)
            OP_RTYPE: begin
                use_rs       = 1'b1;
                use_rt       = 1'b1;
                d_ctl.md     = (alu == ALU_MUL) || (alu == ALU_DIV);
                d_ctl.div    = (alu == ALU_DIV);
                d_ctl.alu_op = d_ctl.md ? 5'd0 : alu;
                d_ctl.we     = (alu != ALU_NOP);
            end
            OP_ADDI: begin
                use_rs         = 1'b1;
                d_ctl.alu_in_b = 1'b1;
                d_ctl.we       = 1'b1;
            end
            OP_LW: begin
                use_rs         = 1'b1;
                d_ctl.alu_in_b = 1'b1;
                d_ctl.we       = 1'b1;
                d_ctl.rwd      = 1'b1;
                d_ctl.lw       = 1'b1;
            end
            OP_SW: begin
                use_rs         = 1'b1;
                use_rd         = 1'b1;
                d_ctl.alu_in_b = 1'b1;
                d_ctl.dmwe     = 1'b1;
            end
            OP_J:   d_ctl.jp = 1'b1;
            OP_JAL: begin
                d_ctl.jp  = 1'b1;
                d_ctl.jal = 1'b1;
                d_ctl.we  = 1'b1;
                d_ctl.rd  = 5'd31;
            end
            OP_BNE: begin
                use_rd       = 1'b1;
                use_rs       = 1'b1;
                d_ctl.br     = 1'b1;
                d_ctl.alu_op = 5'd1;
            end
            OP_BLT: begin
                use_rd       = 1'b1;
                use_rs       = 1'b1;
                d_ctl.brlt   = 1'b1;
                d_ctl.alu_op = 5'd1;
            end
            OP_JR: begin
                use_rd   = 1'b1;
                d_ctl.jr = 1'b1;
            end
            OP_BEX: begin
                use_r30      = 1'b1;
                d_ctl.jp     = 1'b1;
                d_ctl.alu_op = 5'd1;
            end
            OP_SETX: begin
                d_ctl.we = 1'b1;
                d_ctl.rd = 5'd30;
            end
            default: ;
        endcase
        d_ctl.valid = 1'b1;
        if (!bus.insn_valid_d) begin
            d_ctl = '0;
        end
    end

    // A load in X can only forward after M, so a dependent D instruction waits one cycle.
    assign load_use = x_q.valid && x_q.lw && (x_q.rd != 5'd0) && bus.insn_valid_d &&
                      ((use_rs  && (f_rs == x_q.rd)) ||
                       (use_rt  && (f_rt == x_q.rd)) ||
                       (use_rd  && (f_rd == x_q.rd)) ||
                       (use_r30 && (x_q.rd == 5'd30)));

    assign md_active = x_q.valid && x_q.md;
    assign at_max    = (cnt_q == CNT_W'(MD_MAX_CYCLES - 1));

    // ---------------- mul/div FSM: state register ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ---------------- mul/div FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (md_active) begin
                    state_d = BUSY;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (bus.md_ready || at_max) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- mul/div FSM: outputs and front-end control ----------------
    always_comb begin
        md_start   = 1'b0;
        md_timeout = 1'b0;
        md_hold    = 1'b0;
        case (state_q)
            IDLE: begin
                if (md_active) begin
                    md_start = 1'b1;
                    md_hold  = 1'b1;
                end
            end
            BUSY: begin
                if (bus.md_ready) begin
                    md_hold = 1'b0;
                end else if (at_max) begin
                    md_timeout = 1'b1;
                end else begin
                    md_hold = 1'b1;
                end
            end
            default: ;
        endcase
        // A mul/div in X cannot be a branch, so a taken indication then is stale.
        flush_fd = bus.branch_taken_x && !md_active;
        // A flush squashes the dependent instruction, so there is nothing left to stall.
        stall_fd = md_hold || (load_use && !flush_fd);
    end

    // A timed-out mul/div still retires, but must not write a register.
    always_comb begin
        m_d.valid = x_q.valid;
        m_d.dmwe  = x_q.dmwe;
        m_d.rwd   = x_q.rwd;
        m_d.jal   = x_q.jal;
        m_d.we    = x_q.we && !md_timeout;
        m_d.rd    = x_q.rd;
    end

    // ---------------- stage registers ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            x_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else begin
            w_q <= '{valid: m_q.valid, we: m_q.we, rwd: m_q.rwd, jal: m_q.jal, rd: m_q.rd};
            if (md_hold) begin
                m_q <= '0;
            end else begin
                m_q <= m_d;
            end
            if (!md_hold) begin
                if (flush_fd || load_use) begin
                    x_q <= '0;
                end else begin
                    x_q <= d_ctl;
                end
            end
        end
    end

    assign bus.stall_fd   = stall_fd;
    assign bus.flush_fd   = flush_fd;
    assign bus.md_start   = md_start;
    assign bus.md_timeout = md_timeout;
    assign bus.md_is_div  = md_active && x_q.div;
    assign bus.md_count   = cnt_q;

    assign bus.x_valid    = x_q.valid;
    assign bus.x_alu_in_b = x_q.alu_in_b;
    assign bus.x_br       = x_q.br;
    assign bus.x_brlt     = x_q.brlt;
    assign bus.x_jp       = x_q.jp;
    assign bus.x_jr       = x_q.jr;
    assign bus.x_md       = x_q.md;
    assign bus.x_alu_op   = x_q.alu_op;

    assign bus.m_valid    = m_q.valid;
    assign bus.m_dmwe     = m_q.dmwe;

    assign bus.w_valid    = w_q.valid;
    assign bus.w_we       = w_q.we;
    assign bus.w_rwd      = w_q.rwd;
    assign bus.w_jal      = w_q.jal;
    assign bus.w_rd       = w_q.rd;
endmodule
